// File: rtl/spram_wb_arbiter_if.sv
// Wishbone classic two-port bundle for spram_wb_arbiter.
// Port 0 is instruction fetch, port 1 is data. Request on port i is s_cyc[i] & s_stb[i].
// The master modport drives requests. The slave modport (the arbiter) returns ack and read data.
interface spram_wb_arbiter_if;
    logic [1:0]  s_cyc;
    logic [1:0]  s_stb;
    logic [1:0]  s_we;
    logic [3:0]  s_sel0;
    logic [3:0]  s_sel1;
    logic [31:0] s_adr0;
    logic [31:0] s_adr1;
    logic [31:0] s_dat0_i;
    logic [31:0] s_dat1_i;
    logic [31:0] s_dat0_o;
    logic [31:0] s_dat1_o;
    logic [1:0]  s_ack;

    modport master (
        output s_cyc, s_stb, s_we, s_sel0, s_sel1, s_adr0, s_adr1, s_dat0_i, s_dat1_i,
        input  s_dat0_o, s_dat1_o, s_ack
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_sel0, s_sel1, s_adr0, s_adr1, s_dat0_i, s_dat1_i,
        output s_dat0_o, s_dat1_o, s_ack
    );
endinterface

// File: rtl/spram_wb_arbiter.sv
// spram_wb_arbiter: shares one single-port 32-bit RAM (1-cycle read latency, byte write
// enables) between two Wishbone classic slave ports. Only one access is in flight at a time.
// Every transaction takes exactly three cycles:
//   IDLE   : the request is sampled and the winner's address, data, sel and we are captured
//   ACCESS : the RAM pins are driven (ram_ce high, ram_we = sel on writes)
//   ACK    : ack and read data are returned to the winner, and then the FSM goes back to IDLE
//
// Arbitration is round-robin by default. The 'last' register remembers the last winner, and
// a tie is granted to the other port. Reset sets last to 1, so port 0 wins the first tie.
// Define SPRAM_ARB_FIXED_PRIO_EN to use fixed priority instead. Port 0 then always wins a
// tie and the round-robin state does not exist. Ports and latency are the same in both modes.
//
// Address bits above addr_width+1 are ignored, so the RAM aliases through the byte address
// space. Byte-lane bits adr[1:0] are also ignored.
module spram_wb_arbiter #(
    parameter int size       = 32'sh80,
    parameter int addr_width = $clog2(size) - 32'sd2
) (
    input  logic                  clk,
    input  logic                  rst,
    spram_wb_arbiter_if.slave     wb,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_ce,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_d,
    input  logic [31:0]           ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Byte write enables: the sel lanes on a write, and nothing on a read.
    function automatic logic [3:0] byte_we(input logic we, input logic [3:0] sel);
        byte_we = {4{we}} & sel;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [1:0]            req_s;
    logic                  take_s;
    logic                  grant_s;
    logic                  grant_r;
    logic                  we_s;
    logic                  we_r;
    logic [3:0]            sel_s;
    logic [31:0]           dat_s;
    logic [addr_width-1:0] word_s;
    logic                  unused_adr_s;

`ifndef SPRAM_ARB_FIXED_PRIO_EN
    logic                  last_r;
`endif

    // Per-port request qualification, and the decision to start a transaction.
    always_comb begin
        req_s  = wb.s_cyc & wb.s_stb;
        take_s = 1'b0;
        if (state_r == ST_IDLE) begin
            take_s = |req_s;
        end else begin
            take_s = 1'b0;
        end
    end

    // Arbitration: a single requester wins; on a tie, use the configured policy.
    always_comb begin
        grant_s = 1'b0;
        case (req_s)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            2'b11:   grant_s = 1'b0;
`else
            2'b11:   grant_s = ~last_r;
`endif
            default: grant_s = 1'b0;
        endcase
    end

    // Select the winning port's request fields. The word index is taken from adr[addr_width+1:2].
    always_comb begin
        we_s   = 1'b0;
        sel_s  = 4'h0;
        dat_s  = 32'h0;
        word_s = {addr_width{1'b0}};
        if (grant_s) begin
            we_s   = wb.s_we[1];
            sel_s  = wb.s_sel1;
            dat_s  = wb.s_dat1_i;
            word_s = wb.s_adr1[addr_width+1:2];
        end else begin
            we_s   = wb.s_we[0];
            sel_s  = wb.s_sel0;
            dat_s  = wb.s_dat0_i;
            word_s = wb.s_adr0[addr_width+1:2];
        end
    end

    // Gather the address bits that are ignored by design (aliasing and byte lanes).
    always_comb begin
        unused_adr_s = ^{wb.s_adr0[31:addr_width+2], wb.s_adr0[1:0],
                         wb.s_adr1[31:addr_width+2], wb.s_adr1[1:0]};
    end

    // FSM next state: IDLE waits for a request; ACCESS and ACK each last one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_ACK;
            ST_ACK:    state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register. A reset in any state abandons the transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifndef SPRAM_ARB_FIXED_PRIO_EN
    // Round-robin memory: record the winner of every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (take_s) begin
            last_r <= grant_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Transaction registers used in the ACK cycle: the owner and the direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r <= 1'b0;
            we_r    <= 1'b0;
        end else if (take_s) begin
            grant_r <= grant_s;
            we_r    <= we_s;
        end else begin
            grant_r <= grant_r;
            we_r    <= we_r;
        end
    end

    // RAM pin registers: loaded at the IDLE->ACCESS edge, so they are active only during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce   <= 1'b0;
            ram_we   <= 4'h0;
            ram_addr <= {addr_width{1'b0}};
            ram_d    <= 32'h0;
        end else if (take_s) begin
            ram_ce   <= 1'b1;
            ram_we   <= byte_we(we_s, sel_s);
            ram_addr <= word_s;
            ram_d    <= dat_s;
        end else begin
            ram_ce   <= 1'b0;
            ram_we   <= 4'h0;
            ram_addr <= {addr_width{1'b0}};
            ram_d    <= 32'h0;
        end
    end

    // Response: during ACK, ack follows the owner's live cyc (a dropped cycle gets no ack).
    // Read data comes straight from ram_q, which is valid only in this cycle. Writes return zero.
    always_comb begin
        wb.s_ack    = 2'b00;
        wb.s_dat0_o = 32'h0;
        wb.s_dat1_o = 32'h0;
        if (state_r == ST_ACK) begin
            if (grant_r) begin
                wb.s_ack[1] = wb.s_cyc[1];
                if (!we_r) begin
                    wb.s_dat1_o = ram_q;
                end else begin
                    wb.s_dat1_o = 32'h0;
                end
            end else begin
                wb.s_ack[0] = wb.s_cyc[0];
                if (!we_r) begin
                    wb.s_dat0_o = ram_q;
                end else begin
                    wb.s_dat0_o = 32'h0;
                end
            end
        end else begin
            wb.s_ack = 2'b00;
        end
    end

endmodule

// File: tb/tb_spram_wb_arbiter.sv
// Testbench for spram_wb_arbiter. It contains a behavioural single-port RAM and a reference
// model of the arbiter. The model keeps a word array plus the last-grant bit and
// predicts each grant, the RAM pin values, ack and read data.
// Define SPRAM_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_spram_wb_arbiter;
    localparam int SIZE = 128;
    localparam int AW   = 5;
    localparam int WORDS = SIZE / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          preload = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_ce;
    logic [3:0]    ram_we;
    logic [31:0]   ram_d;
    logic [31:0]   ram_q;

    spram_wb_arbiter_if wb();

    spram_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .ram_addr (ram_addr),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        init_word = (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    // Attached RAM: 1-cycle read latency, byte write enables.
    logic [31:0] ram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
        end else if (ram_ce) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            ram_q <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    int          last_m;
    int          total = 0;
    int          bad = 0;

    task automatic clear_inputs();
        wb.s_cyc = 2'b00; wb.s_stb = 2'b00; wb.s_we = 2'b00;
        wb.s_sel0 = 4'h0; wb.s_sel1 = 4'h0;
        wb.s_adr0 = 32'h0; wb.s_adr1 = 32'h0;
        wb.s_dat0_i = 32'h0; wb.s_dat1_i = 32'h0;
    endtask

    // One transaction, starting at a negedge with the DUT in IDLE and ending at the next IDLE negedge.
    task automatic run_txn(input logic [1:0] req, input logic [1:0] w,
                           input logic [3:0] sl0, input logic [3:0] sl1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit drop, input bit hold, output logic [31:0] rd);
        int          g;
        int          idx;
        logic        wr;
        logic [3:0]  sl;
        logic [31:0] a, d, exp_q, exp_d0, exp_d1;
        logic [1:0]  exp_ack;
        logic [3:0]  exp_we;
        logic [AW-1:0] exp_addr;
        wb.s_cyc = req; wb.s_stb = req; wb.s_we = w;
        wb.s_sel0 = sl0; wb.s_sel1 = sl1; wb.s_adr0 = a0; wb.s_adr1 = a1;
        wb.s_dat0_i = d0; wb.s_dat1_i = d1;
        if (req == 2'b11) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = (last_m == 1) ? 0 : 1;
`endif
        end else begin
            g = (req == 2'b10) ? 1 : 0;
        end
        last_m = g;
        wr = w[g]; sl = g ? sl1 : sl0; a = g ? a1 : a0; d = g ? d1 : d0;
        idx = int'((a % SIZE) / 4);
        exp_addr = AW'(idx);
        exp_we = wr ? sl : 4'h0;
        exp_q = ref_mem[idx];

        @(posedge clk); @(negedge clk);   // ACCESS
        total++; if (ram_ce !== 1'b1) begin bad++; $display("FAIL access_ce: got %b want 1", ram_ce); end
        total++; if (ram_addr !== exp_addr) begin bad++; $display("FAIL access_addr: got %h want %h", ram_addr, exp_addr); end
        total++; if (ram_we !== exp_we) begin bad++; $display("FAIL access_we: got %h want %h", ram_we, exp_we); end
        total++; if (ram_d !== d) begin bad++; $display("FAIL access_d: got %h want %h", ram_d, d); end
        total++; if (wb.s_ack !== 2'b00) begin bad++; $display("FAIL access_ack: got %b want 00", wb.s_ack); end
        if (drop) begin wb.s_cyc[g] = 1'b0; wb.s_stb[g] = 1'b0; end

        @(posedge clk); @(negedge clk);   // ACK
        exp_ack = drop ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
        exp_d0 = (g == 0 && !wr) ? exp_q : 32'h0;
        exp_d1 = (g == 1 && !wr) ? exp_q : 32'h0;
        total++; if (wb.s_ack !== exp_ack) begin bad++; $display("FAIL ack: got %b want %b", wb.s_ack, exp_ack); end
        total++; if (wb.s_dat0_o !== exp_d0) begin bad++; $display("FAIL dat0_o: got %h want %h", wb.s_dat0_o, exp_d0); end
        total++; if (wb.s_dat1_o !== exp_d1) begin bad++; $display("FAIL dat1_o: got %h want %h", wb.s_dat1_o, exp_d1); end
        rd = g ? wb.s_dat1_o : wb.s_dat0_o;
        if (wr) for (int b = 0; b < 4; b++) if (sl[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        if (!hold) clear_inputs();

        @(posedge clk); @(negedge clk);   // IDLE again, no bypass
        total++; if (ram_ce !== 1'b0 || wb.s_ack !== 2'b00) begin
            bad++; $display("FAIL idle_quiet: got ce=%b ack=%b want ce=0 ack=00", ram_ce, wb.s_ack);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (wb.s_ack !== 2'b00 || wb.s_dat0_o !== 32'h0 || wb.s_dat1_o !== 32'h0 ||
            ram_ce !== 1'b0 || ram_we !== 4'h0 || ram_addr !== '0 || ram_d !== 32'h0) begin
            bad++;
            $display("FAIL %s: got ack=%b d0=%h d1=%h ce=%b we=%h addr=%h d=%h want all zero",
                     name, wb.s_ack, wb.s_dat0_o, wb.s_dat1_o, ram_ce, ram_we, ram_addr, ram_d);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        last_m = 1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        run_txn(2'b10, 2'b10, 4'h0, 4'hF, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, rd);
        run_txn(2'b10, 2'b00, 4'h0, 4'hF, 32'h0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, rd);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL write_read: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        run_txn(2'b01, 2'b01, 4'hF, 4'h0, 32'h20, 32'h0, 32'h11223344, 32'h0, 1'b0, 1'b0, rd);
        run_txn(2'b01, 2'b01, 4'b0010, 4'h0, 32'h20, 32'h0, 32'h0000AB00, 32'h0, 1'b0, 1'b0, rd);
        run_txn(2'b01, 2'b00, 4'hF, 4'h0, 32'h20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rd);
        total++; if (rd !== 32'h1122AB44) begin bad++; $display("FAIL byte_write: got %h want 1122ab44", rd); end
    endtask

    // Both ports request continuously from reset. The model predicts 0,1,0,1 (or all 0 with fixed priority).
    task automatic test_back_to_back();
        logic [31:0] rd;
        test_reset();
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'b00, 4'hF, 4'hF, 32'h40, 32'h44, 32'h0, 32'h0, 1'b0, (i < 3), rd);
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd;
        run_txn(2'b01, 2'b01, 4'hF, 4'h0, 32'h8, 32'h0, 32'h55, 32'h0, 1'b1, 1'b0, rd);
        run_txn(2'b01, 2'b00, 4'hF, 4'h0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rd);
        total++; if (rd !== 32'h55) begin bad++; $display("FAIL cyc_drop_commit: got %h want 00000055", rd); end
    endtask

    task automatic test_reset_in_access();
        logic [31:0] rd;
        wb.s_cyc = 2'b01; wb.s_stb = 2'b01; wb.s_we = 2'b00; wb.s_adr0 = 32'h10; wb.s_sel0 = 4'hF;
        @(posedge clk); @(negedge clk);
        total++; if (ram_ce !== 1'b1) begin bad++; $display("FAIL rst_pre_access: got %b want 1", ram_ce); end
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); @(negedge clk);
        check_all_zero("rst_in_access");
        rst = 1'b0;
        last_m = 1;
        @(posedge clk); @(negedge clk);
        check_all_zero("rst_no_late_ack");
        run_txn(2'b10, 2'b00, 4'h0, 4'hF, 32'h0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, rd);
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        run_txn(2'b01, 2'b00, 4'hF, 4'h0, SIZE + 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rd);
        run_txn(2'b10, 2'b10, 4'h0, 4'hF, 32'h0, 32'hFFFF_FF86, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, rd);
        run_txn(2'b01, 2'b00, 4'hF, 4'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rd);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_readback: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [1:0]  req;
        for (int i = 0; i < 60; i++) begin
            req = 2'($urandom_range(3, 1));
            run_txn(req, 2'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom,
                    $urandom, $urandom, ($urandom_range(7, 0) == 0), 1'b0, rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        preload = 1'b1;
        @(posedge clk); @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_cyc_drop();
        test_reset_in_access();
        test_alias();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
